// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: redirect/stall control, branch resolution
// feedback, instruction memory port and fetch outputs.
interface fetch_unit_if;
  logic        stall;
  logic        fail_predict;
  logic [12:0] redirect_pc;
  logic        bp_update;
  logic [12:0] bp_pc;
  logic        bp_taken;
  logic [12:0] bp_target;
  logic [10:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [12:0] pcF;
  logic [31:0] instF;
  logic        predF;

  modport master (
    output stall, fail_predict, redirect_pc,
    output bp_update, bp_pc, bp_taken, bp_target,
    output imem_rdata,
    input  imem_addr, pcF, instF, predF
  );

  modport slave (
    input  stall, fail_predict, redirect_pc,
    input  bp_update, bp_pc, bp_taken, bp_target,
    input  imem_rdata,
    output imem_addr, pcF, instF, predF
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, next-PC select and a
// direct-mapped BTB with 2-bit saturating direction counters.
module fetch_unit #(
  parameter int BTB_ENTRIES = 16
) (
  input logic         CLK,
  input logic         NRST,
  fetch_unit_if.slave bus
);
  logic [12:0] pc_q;
  logic [12:0] pc_next;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [6:0]  tag_q [BTB_ENTRIES];
  logic [12:0] tgt_q [BTB_ENTRIES];
  logic [1:0]  cnt_q [BTB_ENTRIES];

  logic [3:0]  f_idx;
  logic [3:0]  u_idx;
  logic        f_hit;
  logic        u_hit;
  logic        pred;
  logic [12:0] redir_al;
  logic [12:0] upd_tgt;
  logic        unused_bp;

  assign f_idx = pc_q[5:2];
  assign u_idx = bus.bp_pc[5:2];

  assign f_hit = valid_q[f_idx]
              && (tag_q[f_idx] == pc_q[12:6]);
  assign u_hit = valid_q[u_idx]
              && (tag_q[u_idx] == bus.bp_pc[12:6]);
  assign pred  = f_hit && cnt_q[f_idx][1];

  assign redir_al  = bus.redirect_pc & 13'h1FFC;
  assign upd_tgt   = bus.bp_target & 13'h1FFC;
  assign unused_bp = ^bus.bp_pc[1:0];

  always_comb begin
    pc_next = pc_q + 13'd4;
    if (!NRST) begin
      pc_next = '0;
    end else if (bus.fail_predict) begin
      pc_next = redir_al;
    end else if (bus.stall) begin
      pc_next = pc_q;
    end else if (pred) begin
      pc_next = tgt_q[f_idx];
    end
  end

  assign bus.imem_addr = pc_next[12:2];
  assign bus.pcF       = pc_q;
  assign bus.instF     = bus.imem_rdata;
  assign bus.predF     = pred;

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_next;
    end
  end

  // Lookup above reads pre-edge contents; writes land next cycle.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= 2'b01;
      end
    end else if (bus.bp_update) begin
      if (u_hit) begin
        if (bus.bp_taken) begin
          tgt_q[u_idx] <= upd_tgt;
          if (cnt_q[u_idx] != 2'b11) begin
            cnt_q[u_idx] <= cnt_q[u_idx] + 2'b01;
          end
        end else if (cnt_q[u_idx] != 2'b00) begin
          cnt_q[u_idx] <= cnt_q[u_idx] - 2'b01;
        end
      end else if (bus.bp_taken) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= bus.bp_pc[12:6];
        tgt_q[u_idx]   <= upd_tgt;
        cnt_q[u_idx]   <= 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic
// against a behavioural PC/BTB model.
module tb_fetch_unit;
  logic CLK = 1'b0;
  logic NRST;
  int   checks = 0;
  int   errors = 0;

  fetch_unit_if bus();

  fetch_unit #(.BTB_ENTRIES(16)) dut (
    .CLK  (CLK),
    .NRST (NRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [2048];
  always @(posedge CLK) bus.imem_rdata <= mem[bus.imem_addr];

  // behavioural model
  int m_pc;
  bit m_v   [16];
  int m_tag [16];
  int m_tgt [16];
  int m_cnt [16];

  function automatic bit m_pred(int pc);
    int i;
    i = (pc >> 2) % 16;
    return m_v[i] && m_tag[i] == (pc >> 6) && m_cnt[i] >= 2;
  endfunction

  function automatic logic [31:0] m_inst();
    return 32'h100 + 32'(m_pc >> 2);
  endfunction

  task automatic idle();
    NRST = 1'b1;
    bus.stall = 1'b0;
    bus.fail_predict = 1'b0;
    bus.redirect_pc = '0;
    bus.bp_update = 1'b0;
    bus.bp_pc = '0;
    bus.bp_taken = 1'b0;
    bus.bp_target = '0;
  endtask

  task automatic cyc(input logic nrst, input logic fp,
                     input logic st, input logic [12:0] rpc,
                     input logic upd, input logic tk,
                     input logic [12:0] upc,
                     input logic [12:0] utg);
    int npc, i, up, ut;
    bit hit;
    NRST = nrst;
    bus.fail_predict = fp;
    bus.stall = st;
    bus.redirect_pc = rpc;
    bus.bp_update = upd;
    bus.bp_taken = tk;
    bus.bp_pc = upc;
    bus.bp_target = utg;
    if (!nrst) begin
      m_pc = 0;
      for (int k = 0; k < 16; k++) begin
        m_v[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_cnt[k] = 1;
      end
    end else begin
      if (fp) npc = int'(rpc) & 'h1FFC;
      else if (st) npc = m_pc;
      else if (m_pred(m_pc)) npc = m_tgt[(m_pc >> 2) % 16];
      else npc = (m_pc + 4) % 8192;
      if (upd) begin
        up = int'(upc);
        ut = int'(utg) & 'h1FFC;
        i = (up >> 2) % 16;
        hit = m_v[i] && m_tag[i] == (up >> 6);
        if (hit && tk) begin
          m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
          m_tgt[i] = ut;
        end else if (hit) begin
          m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
        end else if (tk) begin
          m_v[i] = 1; m_tag[i] = up >> 6;
          m_tgt[i] = ut; m_cnt[i] = 2;
        end
      end
      m_pc = npc;
    end
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic step();
    cyc(1, 0, 0, '0, 0, 0, '0, '0);
  endtask

  task automatic redir(input logic [12:0] pc);
    cyc(1, 1, 0, pc, 0, 0, '0, '0);
  endtask

  task automatic bupd(input logic [12:0] pc, input logic tk,
                      input logic [12:0] tg);
    cyc(1, 0, 1, '0, 1, tk, pc, tg);
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, '0, 0, 0, '0, '0);
    cyc(0, 1, 1, 13'h0abc, 1, 1, 13'h0010, 13'h0200);
    checks++;
    if (bus.pcF !== 13'h0) begin
      errors++;
      $display("FAIL reset_pc: got %h want 0000", bus.pcF);
    end
    checks++;
    if (bus.predF !== 1'b0) begin
      errors++;
      $display("FAIL reset_pred: got %b want 0", bus.predF);
    end
    checks++;
    if (bus.instF !== 32'h100) begin
      errors++;
      $display("FAIL reset_inst: got %h want 00000100", bus.instF);
    end
  endtask

  task automatic test_sequential();
    for (int i = 1; i < 4; i++) begin
      step();
      checks++;
      if (bus.pcF !== 13'(4 * i) || bus.instF !== 32'h100 + 32'(i)
          || bus.predF !== 1'b0) begin
        errors++;
        $display("FAIL seq_%0d: got pc=%h inst=%h pred=%b want pc=%h inst=%h pred=0",
                 i, bus.pcF, bus.instF, bus.predF, 4 * i, 32'h100 + i);
      end
    end
  endtask

  task automatic test_stall();
    redir(13'h0008);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, '0, 0, 0, '0, '0);
      checks++;
      if (bus.pcF !== 13'h8 || bus.instF !== 32'h102) begin
        errors++;
        $display("FAIL stall_hold_%0d: got pc=%h inst=%h want pc=0008 inst=00000102",
                 i, bus.pcF, bus.instF);
      end
    end
    step();
    checks++;
    if (bus.pcF !== 13'hC || bus.instF !== 32'h103) begin
      errors++;
      $display("FAIL stall_resume: got pc=%h inst=%h want pc=000c inst=00000103",
               bus.pcF, bus.instF);
    end
  endtask

  task automatic test_redirect();
    redir(13'h0042);
    checks++;
    if (bus.pcF !== 13'h40 || bus.instF !== 32'h110) begin
      errors++;
      $display("FAIL redirect: got pc=%h inst=%h want pc=0040 inst=00000110",
               bus.pcF, bus.instF);
    end
    cyc(1, 1, 1, 13'h0020, 0, 0, '0, '0);
    checks++;
    if (bus.pcF !== 13'h20) begin
      errors++;
      $display("FAIL redirect_over_stall: got %h want 0020", bus.pcF);
    end
  endtask

  task automatic test_predict();
    bupd(13'h0010, 1, 13'h0080);
    redir(13'h000C);
    step();
    checks++;
    if (bus.pcF !== 13'h10 || bus.predF !== 1'b1) begin
      errors++;
      $display("FAIL pred_hit: got pc=%h pred=%b want pc=0010 pred=1",
               bus.pcF, bus.predF);
    end
    step();
    checks++;
    if (bus.pcF !== 13'h80) begin
      errors++;
      $display("FAIL pred_target: got %h want 0080", bus.pcF);
    end
    bupd(13'h0010, 0, '0);
    bupd(13'h0010, 0, '0);
    redir(13'h0010);
    checks++;
    if (bus.predF !== 1'b0) begin
      errors++;
      $display("FAIL pred_weakened: got %b want 0", bus.predF);
    end
    step();
    checks++;
    if (bus.pcF !== 13'h14) begin
      errors++;
      $display("FAIL pred_seq: got %h want 0014", bus.pcF);
    end
    redir(13'h0020);
    cyc(1, 0, 0, '0, 1, 1, 13'h0020, 13'h0100);
    checks++;
    if (bus.pcF !== 13'h24) begin
      errors++;
      $display("FAIL same_cycle_old_btb: got %h want 0024", bus.pcF);
    end
    redir(13'h0020);
    step();
    checks++;
    if (bus.pcF !== 13'h100) begin
      errors++;
      $display("FAIL same_cycle_new_btb: got %h want 0100", bus.pcF);
    end
  endtask

  task automatic test_alias_saturate();
    for (int i = 0; i < 4; i++) bupd(13'h0010, 1, 13'h0080);
    redir(13'h0050);
    checks++;
    if (bus.predF !== 1'b0) begin
      errors++;
      $display("FAIL alias_pred: got %b want 0", bus.predF);
    end
    step();
    checks++;
    if (bus.pcF !== 13'h54) begin
      errors++;
      $display("FAIL alias_seq: got %h want 0054", bus.pcF);
    end
    bupd(13'h0010, 0, '0);
    redir(13'h0010);
    checks++;
    if (bus.predF !== 1'b1) begin
      errors++;
      $display("FAIL sat_still_taken: got %b want 1", bus.predF);
    end
    step();
    checks++;
    if (bus.pcF !== 13'h80) begin
      errors++;
      $display("FAIL sat_target: got %h want 0080", bus.pcF);
    end
    bupd(13'h0010, 0, '0);
    redir(13'h0010);
    checks++;
    if (bus.predF !== 1'b0) begin
      errors++;
      $display("FAIL sat_second_nt: got %b want 0", bus.predF);
    end
  endtask

  task automatic test_wrap_reset();
    logic [12:0] exp_pc [3];
    exp_pc[0] = 13'h1FF8;
    exp_pc[1] = 13'h1FFC;
    exp_pc[2] = 13'h0000;
    redir(13'h1FF8);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      checks++;
      if (bus.pcF !== exp_pc[i]
          || bus.instF !== 32'h100 + 32'(exp_pc[i] >> 2)) begin
        errors++;
        $display("FAIL wrap_%0d: got pc=%h inst=%h want pc=%h inst=%h",
                 i, bus.pcF, bus.instF, exp_pc[i],
                 32'h100 + 32'(exp_pc[i] >> 2));
      end
    end
    step();
    step();
    cyc(0, 0, 0, '0, 1, 1, 13'h0030, 13'h0200);
    checks++;
    if (bus.pcF !== 13'h0 || bus.predF !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: got pc=%h pred=%b want pc=0000 pred=0",
               bus.pcF, bus.predF);
    end
    redir(13'h0010);
    checks++;
    if (bus.predF !== 1'b0) begin
      errors++;
      $display("FAIL reset_clears_btb: got %b want 0", bus.predF);
    end
    redir(13'h0030);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.predF !== 1'b0 || bus.pcF !== 13'(48 + 4 * i)) begin
        errors++;
        $display("FAIL post_reset_%0d: got pc=%h pred=%b want pc=%h pred=0",
                 i, bus.pcF, bus.predF, 48 + 4 * i);
      end
      step();
    end
  endtask

  task automatic test_random();
    logic        nr, fp, st, up, tk;
    logic [12:0] rpc, upc, utg;
    for (int n = 0; n < 1500; n++) begin
      nr  = ($urandom_range(63) != 0);
      fp  = ($urandom_range(15) == 0);
      st  = ($urandom_range(7) == 0);
      up  = ($urandom_range(2) == 0);
      tk  = ($urandom_range(3) != 0);
      rpc = 13'($urandom);
      upc = 13'($urandom_range(3) << 6) | 13'($urandom_range(15) << 2)
          | 13'($urandom_range(3));
      utg = 13'($urandom);
      if (($urandom_range(3) == 0)) upc = bus.pcF;
      cyc(nr, fp, st, rpc, up, tk, upc, utg);
      checks++;
      if (bus.pcF !== 13'(m_pc) || bus.predF !== m_pred(m_pc)
          || bus.instF !== m_inst()) begin
        errors++;
        $display("FAIL random_%0d: got pc=%h pred=%b inst=%h want pc=%h pred=%b inst=%h",
                 n, bus.pcF, bus.predF, bus.instF, 13'(m_pc),
                 m_pred(m_pc), m_inst());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h100 + 32'(i);
    idle();
    NRST = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_predict();
    test_alias_saturate();
    test_wrap_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter BTB_ENTRIES, default 16, meaning BTB entry count; only 16 is supported; index = pc[5:2].
REQ-002 SHALL have port CLK  in  1  rising-edge clock.
REQ-003 SHALL have port NRST  in  1  reset: synchronous, active-low; clock CLK.
REQ-004 SHALL have port stall  in  1  hold the current fetch (downstream not accepting).
REQ-005 SHALL have port fail_predict  in  1  misprediction flush; redirect fetch.
REQ-006 SHALL have port redirect_pc  in  13  correct byte PC on fail_predict.
REQ-007 SHALL have port bp_update  in  1  resolved-branch update strobe.
REQ-008 SHALL have port bp_pc  in  13  PC of the resolved branch.
REQ-009 SHALL have port bp_taken  in  1  resolved direction.
REQ-010 SHALL have port bp_target  in  13  resolved target.
REQ-011 SHALL have port imem_addr  out  11  instruction memory word address, combinational.
REQ-012 SHALL have port imem_rdata  in  32  synchronous-read data, valid one cycle after imem_addr.
REQ-013 SHALL have port pcF  out  13  PC of the instruction on instF.
REQ-014 SHALL have port instF  out  32  fetched instruction, equal to imem_rdata.
REQ-015 SHALL have port predF  out  1  pcF was predicted taken.

Function
REQ-016 SHALL hold PC register pc_q; pcF = pc_q; pc_q[1:0] always 00.
REQ-017 SHALL compute pc_next with priority: NRST low -> 0; fail_predict -> {redirect_pc[12:2],2'b00}; stall -> pc_q; predF -> BTB target of pc_q; else pc_q+4.
REQ-018 SHALL drive imem_addr = pc_next[12:2] and register pc_q <= pc_next each cycle, so instF is aligned with pcF.
REQ-019 SHALL wrap pc_q+4 modulo 2^13: 0x1FFC -> 0x0000.
REQ-020 SHALL keep per entry: valid, tag pc[12:6] (7 bits), target (13 bits, [1:0] forced 00), 2-bit saturating counter.
REQ-021 SHALL assert predF combinationally iff entry[pc_q[5:2]] is valid, its tag equals pc_q[12:6], and counter >= 2.
REQ-022 SHALL, on bp_update with a hit (valid, tag match): if bp_taken, counter saturating-increment and target <= bp_target; else counter saturating-decrement (3->3 on taken, 0->0 on not-taken).
REQ-023 SHALL, on bp_update with a miss: if bp_taken, write valid=1, tag, target, counter=2; if not taken, leave the entry unchanged.
REQ-024 SHALL apply bp_update regardless of stall and fail_predict.
REQ-025 SHALL perform lookup from pre-edge BTB contents when update and lookup hit the same index in one cycle; the new value is visible next cycle.
REQ-026 SHALL ignore redirect_pc while fail_predict is low, and ignore bp_pc/bp_taken/bp_target while bp_update is low.
REQ-027 SHALL make instF undefined in the cycle fail_predict is high; the downstream flush discards it.

Reset
REQ-028 SHALL, while NRST is low at a CLK edge: pc_q <= 0; all valid <= 0; all counters <= 01; targets and tags <= 0.
REQ-029 SHALL drive imem_addr = 0 while NRST is low, so the first cycle after release gives pcF=0, instF=mem[0], predF=0.
REQ-030 SHALL give reset priority over fail_predict, stall and bp_update; reset mid-update discards the update.

Verification
REQ-031 SHALL pass: reset, then 4 free cycles, mem[i]=0x100+i -> pcF 0,4,8,C; instF 0x100..0x103; predF=0.
REQ-032 SHALL pass: stall high 3 cycles at pcF=0x8 -> pcF=0x8, instF=mem[2] held; resumes at 0xC.
REQ-033 SHALL pass: fail_predict with redirect_pc=0x0042 -> next pcF=0x0040, instF=mem[0x10]; fail_predict with stall -> redirect wins.
REQ-034 SHALL pass: bp_update pc=0x10 taken target=0x80 -> next visit of 0x10 gives predF=1, following pcF=0x80; two not-taken updates -> predF=0, sequential 0x14.
REQ-035 SHALL pass: aliasing, entry for 0x10 allocated, fetch 0x50 (same index, different tag) -> predF=0; counter saturation 3 taken updates then 1 not-taken -> still predicts taken.
REQ-036 SHALL pass: wrap, redirect to 0x1FF8 -> pcF 0x1FF8, 0x1FFC, 0x0000; NRST low mid-run -> pcF=0, all predF=0 afterwards.
